// File: rtl/sel_pkg.sv
// Shared types and helpers for the active-low one-hot select receiver.
// Combinational only; no state, no backpressure.
package sel_pkg;

    localparam int N_LINES_DEF       = 8;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int SEL_W_DEF         = $clog2(N_LINES_DEF);
    localparam int ENC_MAX           = 32;

    typedef logic [SEL_W_DEF-1:0] sel_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED,
        ERROR
    } sel_rx_state_t;

    typedef struct packed {
        logic [5:0] count_low;
        logic [4:0] index;
    } enc_t;

    // Callers pad unused upper lines with ones so they never count as selected.
    function automatic enc_t onehot_low_encode(input logic [ENC_MAX-1:0] lines);
        enc_t r;
        r.count_low = '0;
        r.index     = '0;
        for (int i = 0; i < ENC_MAX; i++) begin
            if (!lines[i]) begin
                r.count_low = r.count_low + 6'd1;
                r.index     = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_sync.sv
// Multi-bit flop-chain synchroniser; resets to all ones (nothing selected).
// Latency STAGES cycles; no backpressure.
module sel_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '1;
        end else begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/sel_decode_rx.sv
// Receives the active-low one-hot select bus: sync, debounce, validate, encode, deliver.
// Latency SYNC_STAGES+STABLE_CYCLES+2 edges from first sample to sel_valid.
// sel_out/sel_valid hold while !sel_ready; one-deep pending slot keeps only the newest index.
module sel_decode_rx
    import sel_pkg::*;
#(
    parameter  int N_LINES       = N_LINES_DEF,
    localparam int SEL_W         = $clog2(N_LINES),
    parameter  int SYNC_STAGES   = 2,
    parameter  int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] a_n,
    output logic [SEL_W-1:0]   sel_out,
    output logic               sel_valid,
    input  logic               sel_ready,
    output logic               err,
    input  logic               err_clr,
    output logic               idle
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [N_LINES-1:0] s;
    logic [N_LINES-1:0] s_prev;
    logic [CNT_W-1:0]   cnt;
    logic               chg;
    logic               stable;

    sel_sync #(
        .WIDTH  (N_LINES),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (a_n),
        .q   (s)
    );

    assign chg = (s != s_prev);
    // The counter still holds the old pattern's count on a change cycle, so mask it.
    assign stable = !chg && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev <= '1;
            cnt    <= '0;
        end else begin
            s_prev <= s;
            if (chg) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    logic [ENC_MAX-1:0] s_pad;
    enc_t               enc;
    logic               unused_enc;
    logic               is_zero;
    logic               is_one;
    logic [SEL_W-1:0]   cand;

    always_comb begin
        s_pad              = '1;
        s_pad[N_LINES-1:0] = s;
    end

    assign enc        = onehot_low_encode(s_pad);
    assign unused_enc = ^enc;
    assign is_zero    = (enc.count_low == 6'd0);
    assign is_one     = (enc.count_low == 6'd1);
    assign cand       = enc.index[SEL_W-1:0];

    sel_rx_state_t state;
    sel_rx_state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (chg) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (stable) begin
                    if (is_one)       state_nxt = LOCKED;
                    else if (is_zero) state_nxt = IDLE;
                    else              state_nxt = ERROR;
                end
            end
            LOCKED, ERROR: begin
                if (chg) state_nxt = SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle <= 1'b1;
            err  <= 1'b0;
        end else begin
            if (stable) idle <= is_zero;
            if (stable && !is_zero && !is_one) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    logic             pend_vld;
    logic [SEL_W-1:0] pend_idx;
    logic             last_vld;
    logic [SEL_W-1:0] last_idx;
    logic             lock_entry;
    logic             cand_new;
    logic             xfer;
    logic             out_free;
    logic             load_out;

    assign lock_entry = (state == SETTLE) && (state_nxt == LOCKED);
    assign cand_new   = lock_entry
                      && !(last_vld && (cand == last_idx))
                      && !(sel_valid && (cand == sel_out));
    assign xfer       = sel_valid && sel_ready;
    assign out_free   = !sel_valid || xfer;
    // A pending index equal to the one just transferred is stale and dropped.
    assign load_out   = out_free && pend_vld && !(xfer && (pend_idx == sel_out));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_out   <= '0;
            sel_valid <= 1'b0;
            pend_vld  <= 1'b0;
            pend_idx  <= '0;
            last_vld  <= 1'b0;
            last_idx  <= '0;
        end else begin
            if (xfer) begin
                last_vld <= 1'b1;
                last_idx <= sel_out;
            end
            if (load_out) begin
                sel_out   <= pend_idx;
                sel_valid <= 1'b1;
            end else if (xfer) begin
                sel_valid <= 1'b0;
            end
            if (cand_new) begin
                pend_vld <= 1'b1;
                pend_idx <= cand;
            end else if (lock_entry || (out_free && pend_vld)) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sel_decode_rx.sv
// Directed, table-driven bench for sel_decode_rx with hand sequences for
// backpressure, back-to-back delivery and asynchronous reset mid-handshake.
module tb_sel_decode_rx;
    import sel_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_n = 8'hFF;
    logic       sel_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic [2:0] sel_out;
    logic       sel_valid;
    logic       err;
    logic       idle;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sel_decode_rx dut (
        .clk       (clk),
        .rst       (rst),
        .a_n       (a_n),
        .sel_out   (sel_out),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .err       (err),
        .err_clr   (err_clr),
        .idle      (idle)
    );

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic       rdy;
        logic       clr;
        int         cyc;
        logic       v;
        sel_idx_t   o;
        logic       e;
        logic       i;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input string tag, input logic [7:0] a, input logic rdy, input logic clr,
                       input int cyc, input logic v, input sel_idx_t o, input logic e, input logic i);
        vec_t t;
        t.tag = tag; t.a = a; t.rdy = rdy; t.clr = clr; t.cyc = cyc;
        t.v = v; t.o = o; t.e = e; t.i = i;
        tbl.push_back(t);
    endtask

    initial begin
        //   tag     a_n   rdy  clr  cyc v  out  err idle
        add("t1a", 8'hFF, 1, 0, 10, 0, 3'd0, 0, 1);
        add("t1b", 8'hFF, 1, 0, 10, 0, 3'd0, 0, 1);
        add("t2a", 8'hDF, 1, 0,  7, 0, 3'd0, 0, 0);
        add("t2b", 8'hDF, 1, 0,  1, 1, 3'd5, 0, 0);
        add("t2c", 8'hDF, 1, 0,  1, 0, 3'd0, 0, 0);
        add("t2d", 8'hFF, 1, 0, 10, 0, 3'd0, 0, 1);
        add("t2e", 8'hDF, 1, 0,  8, 0, 3'd0, 0, 0);
        add("t2f", 8'hDF, 1, 0,  4, 0, 3'd0, 0, 0);
        add("t4a", 8'hFF, 1, 0, 10, 0, 3'd0, 0, 1);
        add("t4b", 8'hBF, 1, 0,  2, 0, 3'd0, 0, 1);
        add("t4c", 8'hFF, 1, 0, 10, 0, 3'd0, 0, 1);
        add("t5a", 8'h7E, 1, 0,  6, 0, 3'd0, 0, 1);
        add("t5b", 8'h7E, 1, 0,  1, 0, 3'd0, 1, 0);
        add("t5c", 8'h7E, 1, 1,  1, 0, 3'd0, 1, 0);
        add("t5d", 8'h7E, 1, 0,  3, 0, 3'd0, 1, 0);
        add("t5e", 8'hFF, 1, 0, 10, 0, 3'd0, 1, 1);
        add("t5f", 8'hFF, 1, 1,  1, 0, 3'd0, 0, 1);
        add("t5g", 8'hFF, 1, 0,  3, 0, 3'd0, 0, 1);

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_vld",  {7'd0, sel_valid}, 8'd0);
        chk("rst_out",  {5'd0, sel_out},   8'd0);
        chk("rst_err",  {7'd0, err},       8'd0);
        chk("rst_idle", {7'd0, idle},      8'd1);
        rst = 1'b0;

        foreach (tbl[k]) begin
            a_n       = tbl[k].a;
            sel_ready = tbl[k].rdy;
            err_clr   = tbl[k].clr;
            repeat (tbl[k].cyc) @(negedge clk);
            chk({tbl[k].tag, "_vld"},  {7'd0, sel_valid}, {7'd0, tbl[k].v});
            if (tbl[k].v) chk({tbl[k].tag, "_out"}, {5'd0, sel_out}, {5'd0, tbl[k].o});
            chk({tbl[k].tag, "_err"},  {7'd0, err},  {7'd0, tbl[k].e});
            chk({tbl[k].tag, "_idle"}, {7'd0, idle}, {7'd0, tbl[k].i});
        end
        err_clr = 1'b0;

        // Backpressure: index 0 held, index 3 queued, then back-to-back transfer.
        sel_ready = 1'b0;
        a_n = 8'hFE;
        repeat (8) @(negedge clk);
        chk("t3_vld0", {7'd0, sel_valid}, 8'd1);
        chk("t3_out0", {5'd0, sel_out},   8'd0);
        a_n = 8'hF7;
        repeat (12) @(negedge clk);
        chk("t3_hold_vld", {7'd0, sel_valid}, 8'd1);
        chk("t3_hold_out", {5'd0, sel_out},   8'd0);
        chk("t3_idle",     {7'd0, idle},      8'd0);
        sel_ready = 1'b1;
        @(negedge clk);
        chk("t3_b2b_vld", {7'd0, sel_valid}, 8'd1);
        chk("t3_b2b_out", {5'd0, sel_out},   8'd3);
        @(negedge clk);
        chk("t3_done_vld", {7'd0, sel_valid}, 8'd0);

        // Asynchronous reset while a delivery is stalled.
        sel_ready = 1'b0;
        a_n = 8'hEF;
        repeat (8) @(negedge clk);
        chk("t6_vld", {7'd0, sel_valid}, 8'd1);
        chk("t6_out", {5'd0, sel_out},   8'd4);
        rst = 1'b1;
        #1;
        chk("t6_arst_vld",  {7'd0, sel_valid}, 8'd0);
        chk("t6_arst_out",  {5'd0, sel_out},   8'd0);
        chk("t6_arst_idle", {7'd0, idle},      8'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        chk("t6_pre_vld", {7'd0, sel_valid}, 8'd0);
        @(negedge clk);
        chk("t6_re_vld", {7'd0, sel_valid}, 8'd1);
        chk("t6_re_out", {5'd0, sel_out},   8'd4);
        sel_ready = 1'b1;
        @(negedge clk);
        chk("t6_xfer_vld", {7'd0, sel_valid}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sel_decode_rx.md
Name: sel_decode_rx

Overview:
- Receive end of the active-low one-hot select bus: eight lines, exactly one driven low, identifies the selected slot.
- Synchronises the lines, debounces them, validates one-hot-low encoding, and encodes to a 3-bit index.
- Delivers each new index on a valid/ready handshake to the downstream control logic.
- Flags illegal multi-low patterns with a sticky error.

Parameters:
- N_LINES, 8, number of active-low select lines; power of two, at least 2.
- SEL_W, $clog2(N_LINES), width of the encoded index (derived; do not override).
- SYNC_STAGES, 2, synchroniser depth (at least 2).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted (at least 1).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_n  input  N_LINES  asynchronous active-low select lines; bit i low means slot i is selected.
- sel_out  output  SEL_W  encoded index of the delivered selection.
- sel_valid  output  1  sel_out holds an undelivered index.
- sel_ready  input  1  downstream accepts sel_out when high together with sel_valid.
- err  output  1  sticky: a stable multi-low pattern was seen.
- err_clr  input  1  single-cycle clear of err.
- idle  output  1  stable pattern is all lines high (nothing selected).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: sel_out=0, sel_valid=0, err=0, idle=1.
- Reset state: synchroniser flops = all ones, debounce counter=0, last_delivered invalid, FSM=IDLE.
- Synchroniser: each a_n bit passes through SYNC_STAGES flops; s = final stage.
- Debounce:
  - Counter clears when s differs from its previous-cycle value; otherwise it increments, saturating at STABLE_CYCLES-1.
  - The pattern is "stable" on the cycle the counter equals STABLE_CYCLES-1.
- Classification of the stable pattern, registered one cycle later:
  - Zero lines low: idle=1, no delivery.
  - Exactly one line low at bit k: candidate index = k, idle=0.
  - Two or more lines low: err set, idle=0, no delivery; last_delivered unchanged.
- FSM states:
  - IDLE: no stable one-hot. Moves to SETTLE on any s change.
  - SETTLE: counting. Moves to LOCKED on stable one-hot, back to IDLE on stable all-high, and to ERROR on stable multi-low.
  - LOCKED: candidate accepted. Any s change moves to SETTLE.
  - ERROR: any s change moves to SETTLE.
- Delivery rule: on entry to LOCKED with candidate != last_delivered (or last_delivered invalid), load a pending slot.
  - If sel_valid=0, the pending slot moves to sel_out and sel_valid=1 on the next cycle.
- Handshake:
  - sel_out and sel_valid hold stable while sel_valid & !sel_ready.
  - A transfer occurs on the rising edge where sel_valid & sel_ready. At that edge last_delivered = sel_out, and sel_valid drops unless the pending slot holds a different index, which then loads directly (back-to-back, no bubble).
  - Newer candidates overwrite the pending slot; only the most recent is kept (one-deep).
  - If pending equals the index in flight, it is discarded.
- Latency: a change of a_n held steady produces sel_valid high SYNC_STAGES+STABLE_CYCLES+2 rising edges after the first edge that samples it. That is 8 edges with defaults.
- Glitches shorter than STABLE_CYCLES after synchronisation produce no delivery and no error.
- Returning to the already-delivered index (A→idle→A) produces no new delivery.
- err behaviour:
  - Set has priority over err_clr in the same cycle.
  - err_clr with no new error clears on the next edge.
- rst mid-handshake: sel_valid drops immediately (asynchronously); the pending slot and last_delivered are cleared.

Decomposition:
- Package sel_pkg:
  - N_LINES_DEF and STABLE_CYCLES_DEF constants.
  - sel_idx_t typedef (logic [SEL_W-1:0]).
  - State enum sel_rx_state_t {IDLE, SETTLE, LOCKED, ERROR}.
  - Pure function onehot_low_encode returning {count_low, index}.
- Sub-module sel_sync: parameterised multi-bit synchroniser, reset value all ones. All remaining logic lives in sel_decode_rx.

Test Plan:
1. Reset, then drive a_n=8'hFF for 20 cycles -> idle=1, sel_valid=0, err=0 throughout.
2. a_n=8'hDF (line 5 low) held, sel_ready=1 -> sel_valid high exactly 8 edges later with sel_out=3'd5 for one cycle, then low. Re-holding 8'hDF after an 8'hFF interlude gives no second delivery.
3. sel_ready=0, a_n goes 8'hFE, settles, then 8'hF7 settles -> sel_out stays 0 with sel_valid=1. On sel_ready=1, index 0 transfers, then index 3 follows on the next cycle with no bubble.
4. 2-cycle pulse a_n=8'hBF on an 8'hFF background -> no sel_valid, no err, idle stays 1.
5. a_n=8'h7E (lines 0 and 7 low) held -> err=1 after debounce, no delivery. err_clr pulse while 8'h7E is still held and re-stabilising keeps err=1. After a_n=8'hFF settles, err_clr clears it.
6. Assert rst while sel_valid=1 and sel_ready=0 -> sel_valid=0 and sel_out=0 within the same cycle (asynchronous). After release with the same a_n, the index is delivered again as a new transfer.
